// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
//   Shares one pipelined, fixed-latency main memory between I-cache and
//   D-cache miss handling. One pending miss is picked in IDLE, the whole
//   block is requested one word per cycle, the returned words are streamed
//   into the chosen cache's data array, and that cache's done is pulsed.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   i_miss/i_addr           I-cache miss request (level) and byte address
//   d_miss/d_addr           D-cache miss request (level) and byte address
//   mem_en/mem_addr         memory read request, one word per cycle
//   mem_data_valid/mem_data memory return, MEM_LATENCY cycles after mem_en
//   fill_we/fill_sel/fill_word/fill_data
//                           data-array write (sel 0 = I, 1 = D)
//   i_done/d_done           one-cycle block-complete pulse
//   busy                    a fill is in progress (state != IDLE)
module cache_fill_arbiter #(
   parameter int WORDS_PER_BLOCK = 8,
   parameter int MEM_LATENCY     = 4,
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 16,
   localparam int WB             = $clog2(WORDS_PER_BLOCK)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_miss,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              d_miss,
   input  logic [ADDR_W-1:0] d_addr,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_data_valid,
   input  logic [DATA_W-1:0] mem_data,
   output logic              fill_we,
   output logic              fill_sel,
   output logic [WB-1:0]     fill_word,
   output logic [DATA_W-1:0] fill_data,
   output logic              i_done,
   output logic              d_done,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t                 r_state;
   logic                   r_sel;
   logic                   r_last;       // last granted requester, 0 = I
   logic [ADDR_W-WB-2:0]   r_blk;
   logic [WB:0]            r_issue;      // extra MSB flags "all issued"
   logic [WB:0]            r_recv;
   logic [MEM_LATENCY-1:0] r_pend;       // mem_en history, one bit per cycle
   logic                   r_i_done;
   logic                   r_d_done;

   logic                   w_grant_d;
   logic                   w_mem_en;
   logic                   w_accept;
   logic [MEM_LATENCY:0]   w_pend_nxt;
   logic                   w_unused_addr_bits;

   // Both pending: grant whichever was not granted last time.
   assign w_grant_d = d_miss & (~i_miss | ~r_last);

   assign w_mem_en  = (r_state == S_FILL) & ~r_issue[WB];

   // A return is taken only if this fill issued a read exactly MEM_LATENCY
   // cycles ago. r_pend is cleared by reset, so responses to reads issued
   // before a reset can never land in a later fill.
   assign w_accept  = (r_state == S_FILL) & mem_data_valid &
                      r_pend[MEM_LATENCY-1] & ~r_recv[WB];

   assign w_pend_nxt = {r_pend, w_mem_en};

   assign w_unused_addr_bits = ^{i_addr[WB:0], d_addr[WB:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_sel    <= 1'b0;
         r_last   <= 1'b0;
         r_blk    <= '0;
         r_issue  <= '0;
         r_recv   <= '0;
         r_pend   <= '0;
         r_i_done <= 1'b0;
         r_d_done <= 1'b0;
      end else begin
         r_pend   <= w_pend_nxt[MEM_LATENCY-1:0];
         r_i_done <= 1'b0;
         r_d_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_miss | d_miss) begin
                  r_sel   <= w_grant_d;
                  r_last  <= w_grant_d;
                  r_blk   <= w_grant_d ? d_addr[ADDR_W-1:WB+1]
                                       : i_addr[ADDR_W-1:WB+1];
                  r_issue <= '0;
                  r_recv  <= '0;
                  r_state <= S_FILL;
               end
            end
            S_FILL: begin
               if (w_mem_en)
                  r_issue <= r_issue + 1'b1;
               if (w_accept) begin
                  r_recv <= r_recv + 1'b1;
                  if (r_recv == (WB+1)'(WORDS_PER_BLOCK-1)) begin
                     r_state  <= S_DONE;
                     r_i_done <= ~r_sel;
                     r_d_done <= r_sel;
                  end
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_en    = w_mem_en;
   assign mem_addr  = w_mem_en ? {r_blk, r_issue[WB-1:0], 1'b0} : '0;
   assign fill_we   = w_accept;
   assign fill_sel  = r_sel;
   assign fill_word = r_recv[WB-1:0];
   assign fill_data = mem_data;
   assign i_done    = r_i_done;
   assign d_done    = r_d_done;
   assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
module tb_cache_fill_arbiter;
   localparam int W  = 8;
   localparam int L  = 4;
   localparam int AW = 16;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_miss = 1'b0, d_miss = 1'b0;
   logic [AW-1:0] i_addr = '0, d_addr = '0;
   logic          mem_data_valid = 1'b0;
   logic [DW-1:0] mem_data = '0;
   logic          mem_en, fill_we, fill_sel, i_done, d_done, busy;
   logic [AW-1:0] mem_addr;
   logic [2:0]    fill_word;
   logic [DW-1:0] fill_data;

   cache_fill_arbiter #(.WORDS_PER_BLOCK(W), .MEM_LATENCY(L), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
      .mem_en(mem_en), .mem_addr(mem_addr),
      .mem_data_valid(mem_data_valid), .mem_data(mem_data),
      .fill_we(fill_we), .fill_sel(fill_sel), .fill_word(fill_word), .fill_data(fill_data),
      .i_done(i_done), .d_done(d_done), .busy(busy)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] memf(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C96;
   endfunction

   // memory pipeline: slot c holds the read issued at cycle c-L
   bit            mv [64];
   logic [AW-1:0] ma [64];

   // reference: a fill granted at cycle t0 has a fixed timeline relative to t0
   bit            armed = 0;
   bit            act = 0, rsel = 0, rlast = 0;
   int            t0 = 0;
   int            rblk = 0;
   bit            last_i_done = 0, last_d_done = 0;
   int            done_cyc[$];
   bit            done_sel[$];

   always @(negedge clk) begin : mon
      int k;
      bit e_busy, e_en, e_we;
      k      = cyc - t0;
      e_busy = act && k >= 1 && k <= W+L+1;
      e_en   = act && k >= 1 && k <= W;
      e_we   = act && k >= L+1 && k <= W+L;
      if (armed) begin
         chk("busy", busy, e_busy);
         chk("mem_en", mem_en, e_en);
         if (e_en) chk("mem_addr", mem_addr, rblk + 2*(k-1));
         chk("fill_we", fill_we, e_we);
         if (e_we) begin
            chk("fill_word", fill_word, k-1-L);
            chk("fill_data", fill_data, memf(16'(rblk + 2*(k-1-L))));
         end
         if (e_busy) chk("fill_sel", fill_sel, rsel);
         chk("i_done", i_done, act && k == W+L+1 && !rsel);
         chk("d_done", d_done, act && k == W+L+1 && rsel);
      end
      mv[(cyc+L)%64] = (mem_en === 1'b1);
      ma[(cyc+L)%64] = mem_addr;
      last_i_done = (i_done === 1'b1);
      last_d_done = (d_done === 1'b1);
      if (i_done === 1'b1) begin done_cyc.push_back(cyc); done_sel.push_back(1'b0); end
      if (d_done === 1'b1) begin done_cyc.push_back(cyc); done_sel.push_back(1'b1); end
      if (!rst_n) begin
         armed = 1;
         act   = 0;
         rlast = 0;
      end else if (!act || k >= W+L+2) begin
         if (i_miss || d_miss) begin
            rsel  = (i_miss && d_miss) ? !rlast : d_miss;
            rlast = rsel;
            rblk  = int'((rsel ? d_addr : i_addr) & 16'hFFF0);
            t0    = cyc;
            act   = 1;
         end else act = 0;
      end
      cyc++;
   end

   bit auto_drop = 1, rnd_en = 0, spur_en = 0;

   // advance one cycle and drive that cycle's inputs
   task automatic step();
      int s;
      @(posedge clk);
      #1;
      s = cyc % 64;
      if (auto_drop && last_i_done) i_miss = 1'b0;
      if (auto_drop && last_d_done) d_miss = 1'b0;
      mem_data_valid = mv[s];
      mem_data       = mv[s] ? memf(ma[s]) : 16'h0;
      if (spur_en && !mv[s] && (!act || cyc - t0 >= W+L+1) && $urandom_range(4) == 0) begin
         mem_data_valid = 1'b1;
         mem_data       = 16'($urandom);
      end
      if (rnd_en) begin
         rst_n = ($urandom_range(399) != 0);
         if (!i_miss && $urandom_range(5) == 0) begin i_miss = 1'b1; i_addr = 16'($urandom); end
         else if (i_miss && $urandom_range(9) == 0) i_addr = 16'($urandom);
         else if (i_miss && $urandom_range(39) == 0) i_miss = 1'b0;
         if (!d_miss && $urandom_range(5) == 0) begin d_miss = 1'b1; d_addr = 16'($urandom); end
         else if (d_miss && $urandom_range(9) == 0) d_addr = 16'($urandom);
         else if (d_miss && $urandom_range(39) == 0) d_miss = 1'b0;
      end
   endtask

   task automatic reset_dut();
      rst_n = 1'b0; i_miss = 1'b0; d_miss = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      int st, n0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // I miss only at 0x1234
      reset_dut();
      n0 = done_cyc.size();
      i_addr = 16'h1234; i_miss = 1'b1; st = cyc;
      repeat (20) step();
      chk("s1_done_cnt", done_cyc.size() - n0, 1);
      if (done_cyc.size() > n0) begin
         chk("s1_done_cyc", done_cyc[n0] - st, 13);
         chk("s1_done_sel", done_sel[n0], 0);
      end

      // both held from cycle 0: D first, then I
      reset_dut();
      n0 = done_cyc.size();
      i_addr = 16'h2000; d_addr = 16'h3010; i_miss = 1'b1; d_miss = 1'b1; st = cyc;
      repeat (32) step();
      chk("s2_done_cnt", done_cyc.size() - n0, 2);
      if (done_cyc.size() >= n0 + 2) begin
         chk("s2_d_cyc", done_cyc[n0] - st, 13);
         chk("s2_d_sel", done_sel[n0], 1);
         chk("s2_i_cyc", done_cyc[n0+1] - st, 27);
         chk("s2_i_sel", done_sel[n0+1], 0);
      end

      // both held continuously: alternation D, I, D
      reset_dut();
      auto_drop = 0;
      n0 = done_cyc.size();
      i_addr = 16'h4440; d_addr = 16'h5550; i_miss = 1'b1; d_miss = 1'b1;
      repeat (45) step();
      chk("s3_done_cnt", done_cyc.size() - n0, 3);
      if (done_cyc.size() >= n0 + 3) begin
         chk("s3_g0", done_sel[n0], 1);
         chk("s3_g1", done_sel[n0+1], 0);
         chk("s3_g2", done_sel[n0+2], 1);
      end
      auto_drop = 1;

      // reset at cycle 6 of a fill: no done ever
      reset_dut();
      n0 = done_cyc.size();
      i_addr = 16'h0400; i_miss = 1'b1;
      repeat (6) step();
      rst_n = 1'b0; i_miss = 1'b0;
      step();
      rst_n = 1'b1;
      repeat (20) step();
      chk("s4_no_done", done_cyc.size() - n0, 0);

      // stray valids in IDLE, then a normal D fill
      reset_dut();
      n0 = done_cyc.size();
      repeat (3) begin mem_data_valid = 1'b1; mem_data = 16'hBEEF; step(); end
      d_addr = 16'h0A16; d_miss = 1'b1; st = cyc;
      repeat (16) step();
      chk("s5_done_cnt", done_cyc.size() - n0, 1);
      if (done_cyc.size() > n0) chk("s5_done_cyc", done_cyc[n0] - st, 13);

      // d_miss dropped at cycle 3, address changed: block still completes
      reset_dut();
      n0 = done_cyc.size();
      d_addr = 16'h00F0; d_miss = 1'b1; st = cyc;
      repeat (3) step();
      d_miss = 1'b0; d_addr = 16'h7777;
      repeat (15) step();
      chk("s6_done_cnt", done_cyc.size() - n0, 1);
      if (done_cyc.size() > n0) begin
         chk("s6_done_cyc", done_cyc[n0] - st, 13);
         chk("s6_done_sel", done_sel[n0], 1);
      end

      // randomized traffic with occasional resets and stray valids
      reset_dut();
      rnd_en = 1; spur_en = 1;
      repeat (3000) step();
      rnd_en = 0; spur_en = 0;
      rst_n = 1'b1; i_miss = 1'b0; d_miss = 1'b0;
      repeat (20) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
